// File: rtl/pwm_peripheral.sv
// Register bank plus 16-channel PWM generator with one shared duty and a prescaled 8-bit period counter.
// Optional PWM_SHADOW_EN: duty is latched at each period start so mid-period writes never glitch a pulse.
module pwm_peripheral #(
  parameter int CLK_DIV  = 13,
  parameter int NUM_REGS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic        period_start,
  output logic [15:0] uo_out
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [15:0] en_out;
  logic [15:0] pwm_en;
  logic [7:0]  duty;
  logic [7:0]  duty_act;
  logic [15:0] presc;
  logic [7:0]  pcnt_p0;
  logic        tick;
  logic        wrap;
  logic        addr_ok;
  logic        lvl_p0;

  // Duty 0xFF is full-on; otherwise high for the first duty steps of the period.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] d);
    return (d == 8'hFF) ? 1'b1 : (cnt < d);
  endfunction

  assign addr_ok = (wr_addr < 7'(NUM_REGS));
  assign tick    = (presc == PRESC_MAX);
  assign wrap    = tick && (pcnt_p0 == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out <= '0;
      pwm_en <= '0;
      duty   <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !addr_ok;
      if (wr_en && addr_ok) begin
        case (wr_addr)
          7'd0:    en_out[7:0]  <= wr_data;
          7'd1:    en_out[15:8] <= wr_data;
          7'd2:    pwm_en[7:0]  <= wr_data;
          7'd3:    pwm_en[15:8] <= wr_data;
          7'd4:    duty         <= wr_data;
          default: ;
        endcase
      end
    end
  end

  // Stage p0: prescaler and PWM step counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      pcnt_p0      <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? 16'd0 : presc + 16'd1;
      period_start <= wrap;
      if (tick)
        pcnt_p0 <= pcnt_p0 + 8'd1;
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] duty_sh;

  // Non-blocking load picks up the pre-write duty when a write coincides with the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)
      duty_sh <= '0;
    else if (wrap)
      duty_sh <= duty;
  end

  assign duty_act = duty_sh;
`else
  assign duty_act = duty;
`endif

  assign lvl_p0 = pwm_level(pcnt_p0, duty_act);

  // Stage p1: registered pins
  always_ff @(posedge clk) begin
    if (!rst_n)
      uo_out <= '0;
    else
      uo_out <= en_out & (~pwm_en | {16{lvl_p0}});
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV=2 (512-clock period).
// Shadow-duty expectations follow PWM_SHADOW_EN when the bench is built with it.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        period_start;
  logic [15:0] uo_out;

  int checks = 0;
  int errors = 0;

  pwm_peripheral #(.CLK_DIV(2), .NUM_REGS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .period_start (period_start),
    .uo_out       (uo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; the strobe is seen by the next posedge.
  task automatic write(input logic [6:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 1100);
    chk(tag, 32'(period_start), 32'd1);
  endtask

  initial begin
    int n, hi_a, hi_b, other, ps_cnt, lo;
    int exp_cur;

    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 7'd0;
    wr_data = 8'hFF;

    // Reset held with a write strobe active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_uo", 32'(uo_out), 32'h0);
      chk("rst_err", 32'(wr_err), 32'd0);
      chk("rst_ps", 32'(period_start), 32'd0);
    end
    rst_n = 1'b1;
    wr_en = 1'b0;

    // First wrap after release lands exactly 256*2 clocks later
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 600);
    chk("first_period", 32'(n), 32'd512);
    chk("no_reg_written", 32'(uo_out), 32'h0);

    // Static-on with two-cycle latency
    write(7'd0, 8'hFF);
    chk("static_lat", 32'(uo_out), 32'h0000);
    write(7'd1, 8'h81);
    chk("static_lo", 32'(uo_out), 32'h00FF);
    @(negedge clk);
    chk("static_all", 32'(uo_out), 32'h81FF);
    write(7'd0, 8'h00);
    chk("static_hold", 32'(uo_out), 32'h81FF);
    @(negedge clk);
    chk("static_clr", 32'(uo_out), 32'h8100);

    // Unimplemented addresses
    write(7'd5, 8'hFF);
    chk("err_a5", 32'(wr_err), 32'd1);
    @(negedge clk);
    chk("err_a5_end", 32'(wr_err), 32'd0);
    chk("err_a5_uo", 32'(uo_out), 32'h8100);
    write(7'd5, 8'h00);
    chk("err_b2b_1", 32'(wr_err), 32'd1);
    write(7'h7F, 8'hFF);
    chk("err_b2b_2", 32'(wr_err), 32'd1);
    @(negedge clk);
    chk("err_b2b_end", 32'(wr_err), 32'd0);
    @(negedge clk);
    chk("err_uo", 32'(uo_out), 32'h8100);

    // PWM on channel 0 at duty 0x40
    write(7'd1, 8'h00);
    write(7'd0, 8'h01);
    write(7'd2, 8'h01);
    write(7'd4, 8'h40);
    wait_ps("pwm_sync");
    hi_a = 0; hi_b = 0; other = 0; ps_cnt = 0;
    for (int i = 1; i <= 512; i++) begin
      @(negedge clk);
      if (uo_out[0]) begin
        if (i <= 128) hi_a++;
        else hi_b++;
      end
      if (uo_out[15:1] != 15'd0) other++;
      if (period_start) ps_cnt++;
    end
    chk("pwm_high", 32'(hi_a), 32'd128);
    chk("pwm_low", 32'(hi_b), 32'd0);
    chk("pwm_other", 32'(other), 32'd0);
    chk("pwm_ps_count", 32'(ps_cnt), 32'd1);
    chk("pwm_ps_at_512", 32'(period_start), 32'd1);

    // Duty extremes over two periods
    write(7'd4, 8'h00);
    wait_ps("d00_sync");
    hi_a = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (uo_out[0]) hi_a++;
    end
    chk("duty00_high", 32'(hi_a), 32'd0);
    write(7'd4, 8'hFF);
    wait_ps("dff_sync");
    lo = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (!uo_out[0]) lo++;
    end
    chk("dutyff_low", 32'(lo), 32'd0);

    // Mid-period duty change 0x40 -> 0xC0 at pcnt 0x10
    write(7'd4, 8'h40);
    wait_ps("mid_sync");
`ifdef PWM_SHADOW_EN
    exp_cur = 128;
`else
    exp_cur = 384;
`endif
    hi_a = 0; hi_b = 0; ps_cnt = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (uo_out[0]) begin
        if (i <= 512) hi_a++;
        else hi_b++;
      end
      if (period_start) ps_cnt++;
      if (i == 32) begin
        wr_en   = 1'b1;
        wr_addr = 7'd4;
        wr_data = 8'hC0;
      end
      if (i == 33) wr_en = 1'b0;
    end
    chk("mid_cur_high", 32'(hi_a), 32'(exp_cur));
    chk("mid_next_high", 32'(hi_b), 32'd384);
    chk("mid_ps_count", 32'(ps_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
